// File: rtl/id_stage_pipe_if.sv
// id_stage_pipe_if: fetch-side, write-back and execute-side signals of the
// decode stage. "master" is the environment (fetch/WB/execute), "slave" is
// the stage itself.
interface id_stage_pipe_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_instr;
  logic [DATA_W-1:0] in_pc;
  logic              wb_en;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_pc;
  logic [DATA_W-1:0] out_rs1_data;
  logic [DATA_W-1:0] out_rs2_data;
  logic [DATA_W-1:0] out_imm;
  logic [ADDR_W-1:0] out_rd;
  logic [3:0]        out_alu_ctrl;
  logic              out_reg_write;
  logic              out_mem_read;
  logic              out_illegal;

  modport master (
    output in_valid, in_instr, in_pc, wb_en, wb_addr, wb_data, flush, out_ready,
    input  in_ready, out_valid, out_pc, out_rs1_data, out_rs2_data, out_imm,
           out_rd, out_alu_ctrl, out_reg_write, out_mem_read, out_illegal
  );

  modport slave (
    input  in_valid, in_instr, in_pc, wb_en, wb_addr, wb_data, flush, out_ready,
    output in_ready, out_valid, out_pc, out_rs1_data, out_rs2_data, out_imm,
           out_rd, out_alu_ctrl, out_reg_write, out_mem_read, out_illegal
  );
endinterface

// File: rtl/id_stage_pipe.sv
// id_stage_pipe: decode stage with register file and registered ID/EX outputs.
// Decodes R / addi / J / load, sign-extends imm, reads rs/rt, stalls one
// bubble on load-use, flushes on request and flags unknown opcodes.
// Optional macro ID_BYPASS_EN: forward a same-cycle write-back into the
// captured source operands instead of the pre-write register value.
module id_stage_pipe #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5
)(
  input  logic          clk,
  input  logic          rst_n,
  id_stage_pipe_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_REGS);

  localparam logic [5:0] OP_R    = 6'd0;
  localparam logic [5:0] OP_ADDI = 6'd1;
  localparam logic [5:0] OP_J    = 6'd2;
  localparam logic [5:0] OP_LD   = 6'd3;

  typedef struct packed {
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] rs1;
    logic [DATA_W-1:0] rs2;
    logic [DATA_W-1:0] imm;
    logic [ADDR_W-1:0] dst;
    logic [3:0]        alu;
    logic              rw;
    logic              mr;
    logic              ill;
  } idex_t;

  // instruction fields
  logic [5:0]        op;
  logic [ADDR_W-1:0] rs, rt, rd;
  assign op = bus.in_instr[31:26];
  assign rs = bus.in_instr[25:21];
  assign rt = bus.in_instr[20:16];
  assign rd = bus.in_instr[15:11];

  // register file; upper address bits are dropped when NUM_REGS < 32
  logic [NUM_REGS-1:0][DATA_W-1:0] regs;
  logic [IDX_W-1:0]  rs_idx, rt_idx, wb_idx;
  logic              wb_we;
  logic [DATA_W-1:0] rs_val, rt_val;

  assign rs_idx = rs[IDX_W-1:0];
  assign rt_idx = rt[IDX_W-1:0];
  assign wb_idx = bus.wb_addr[IDX_W-1:0];
  assign wb_we  = bus.wb_en && (wb_idx != '0);

  // register write port; entry 0 is never written so it reads as zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     regs <= '0;
    else if (wb_we) regs[wb_idx] <= bus.wb_data;
  end

  // operand read, optionally forwarding the write-back in flight
  always_comb begin
    rs_val = (rs_idx == '0) ? '0 : regs[rs_idx];
    rt_val = (rt_idx == '0) ? '0 : regs[rt_idx];
`ifdef ID_BYPASS_EN
    if (wb_we && wb_idx == rs_idx) rs_val = bus.wb_data;
    if (wb_we && wb_idx == rt_idx) rt_val = bus.wb_data;
`endif
  end

  // decode of the instruction currently presented by fetch
  idex_t dec;
  always_comb begin
    dec     = '0;
    dec.pc  = bus.in_pc;
    dec.rs1 = rs_val;
    dec.rs2 = rt_val;
    dec.imm = DATA_W'($signed(bus.in_instr[15:0]));
    unique case (op)
      OP_R:    begin dec.alu = 4'd1; dec.dst = rd; dec.rw = 1'b1; dec.imm = '0; end
      OP_ADDI: begin dec.alu = 4'd2; dec.dst = rt; dec.rw = 1'b1; end
      OP_J:    begin dec.alu = 4'd0; dec.dst = '0; end
      OP_LD:   begin dec.alu = 4'd3; dec.dst = rt; dec.rw = 1'b1; dec.mr = 1'b1; end
      default: dec.ill = 1'b1;
    endcase
    // r0 is not a real destination
    if (dec.dst == '0) dec.rw = 1'b0;
  end

  // ID/EX state
  idex_t idex;
  logic  vld, hazard, in_ready, accept;

  // load in ID/EX feeding a source of the next op needs one bubble;
  // rt is only a source for R-type
  assign hazard = bus.in_valid && vld && idex.mr && (idex.dst != '0) &&
                  ((idex.dst == rs) || (op == OP_R && idex.dst == rt));
  assign in_ready = !bus.flush && !hazard && (!vld || bus.out_ready);
  assign accept   = bus.in_valid && in_ready;

  // ID/EX register: flush wins, then accept, then drain on out_ready
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld  <= 1'b0;
      idex <= '0;
    end else if (bus.flush) begin
      vld <= 1'b0;
    end else if (accept) begin
      vld  <= 1'b1;
      idex <= dec;
    end else if (bus.out_ready) begin
      vld <= 1'b0;
    end
  end

  assign bus.in_ready      = in_ready;
  assign bus.out_valid     = vld;
  assign bus.out_pc        = idex.pc;
  assign bus.out_rs1_data  = idex.rs1;
  assign bus.out_rs2_data  = idex.rs2;
  assign bus.out_imm       = idex.imm;
  assign bus.out_rd        = idex.dst;
  assign bus.out_alu_ctrl  = idex.alu;
  assign bus.out_reg_write = idex.rw;
  assign bus.out_mem_read  = idex.mr;
  assign bus.out_illegal   = idex.ill;
endmodule

// File: tb/tb_id_stage_pipe.sv
// tb_id_stage_pipe: directed test-plan sequences with literal expectations,
// then randomized traffic, all compared every cycle against a reference model.
module tb_id_stage_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  id_stage_pipe_if #(.DATA_W(32), .ADDR_W(5)) bus ();
  id_stage_pipe #(.DATA_W(32), .NUM_REGS(32), .ADDR_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] pc, rs1, rs2, imm;
    logic [4:0]  rd;
    logic [3:0]  alu;
    logic        rw, mr, ill;
  } exp_t;

  logic [31:0] mreg [32];
  logic        mv;
  exp_t        me;

  function automatic bit model_ready();
    logic [31:0] w;
    bit haz;
    w = bus.in_instr;
    haz = bus.in_valid && mv && me.mr && me.rd != 0 &&
          (me.rd == w[25:21] || (w[31:26] == 0 && me.rd == w[20:16]));
    return !bus.flush && !haz && (!mv || bus.out_ready);
  endfunction

  function automatic exp_t model_decode();
    exp_t e;
    logic [31:0] w;
    logic [4:0] rs, rt;
    int op;
    w  = bus.in_instr;
    op = int'(w[31:26]);
    rs = w[25:21];
    rt = w[20:16];
    e.pc  = bus.in_pc;
    e.rs1 = mreg[rs];
    e.rs2 = mreg[rt];
`ifdef ID_BYPASS_EN
    if (bus.wb_en && bus.wb_addr != 0 && bus.wb_addr == rs) e.rs1 = bus.wb_data;
    if (bus.wb_en && bus.wb_addr != 0 && bus.wb_addr == rt) e.rs2 = bus.wb_data;
`endif
    e.imm = (op == 0) ? 32'h0 : {{16{w[15]}}, w[15:0]};
    e.ill = (op > 3);
    e.mr  = (op == 3);
    case (op)
      0: begin e.alu = 4'd1; e.rd = w[15:11]; end
      1: begin e.alu = 4'd2; e.rd = rt; end
      3: begin e.alu = 4'd3; e.rd = rt; end
      default: begin e.alu = 4'd0; e.rd = 5'd0; end
    endcase
    e.rw = (op == 0 || op == 1 || op == 3) && e.rd != 0;
    return e;
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    bit take;
    if (!rst_n) begin
      mv <= 1'b0;
      me <= '{default: 0};
      for (int i = 0; i < 32; i++) mreg[i] <= 32'h0;
    end else begin
      take = bus.in_valid && model_ready();
      if (bus.flush) mv <= 1'b0;
      else if (take) begin mv <= 1'b1; me <= model_decode(); end
      else if (bus.out_ready) mv <= 1'b0;
      if (bus.wb_en && bus.wb_addr != 0) mreg[bus.wb_addr] <= bus.wb_data;
    end
  end

  // per-cycle compare, away from the active edge
  always @(negedge clk) begin
    if (rst_n) begin
      check("m_out_valid", 32'(bus.out_valid), 32'(mv));
      check("m_in_ready", 32'(bus.in_ready), 32'(model_ready()));
      if (mv) begin
        check("m_pc",   bus.out_pc, me.pc);
        check("m_rs1",  bus.out_rs1_data, me.rs1);
        check("m_rs2",  bus.out_rs2_data, me.rs2);
        check("m_imm",  bus.out_imm, me.imm);
        check("m_rd",   32'(bus.out_rd), 32'(me.rd));
        check("m_alu",  32'(bus.out_alu_ctrl), 32'(me.alu));
        check("m_rw",   32'(bus.out_reg_write), 32'(me.rw));
        check("m_mr",   32'(bus.out_mem_read), 32'(me.mr));
        check("m_ill",  32'(bus.out_illegal), 32'(me.ill));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.in_valid = 1'b0; bus.in_instr = '0; bus.in_pc = '0;
    bus.wb_en = 1'b0; bus.wb_addr = '0; bus.wb_data = '0;
    bus.flush = 1'b0; bus.out_ready = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin : stim
    logic [31:0] s_pc, s_imm;
    logic [4:0]  s_rd;
    logic [5:0]  op;
    logic [31:0] b_exp;
    idle_inputs();
    #12;
    check("reset_out_valid", 32'(bus.out_valid), 32'h0);
    check("reset_in_ready", 32'(bus.in_ready), 32'h1);
    @(negedge clk); rst_n = 1'b1;
    step();

    // addi r5 = r0 + -1
    bus.in_valid = 1; bus.in_instr = 32'h0405FFFF; bus.in_pc = 32'h100;
    step(); bus.in_valid = 0;
    check("addi_valid", 32'(bus.out_valid), 32'h1);
    check("addi_rd", 32'(bus.out_rd), 32'd5);
    check("addi_alu", 32'(bus.out_alu_ctrl), 32'h2);
    check("addi_imm", bus.out_imm, 32'hFFFFFFFF);
    check("addi_rw", 32'(bus.out_reg_write), 32'h1);
    check("addi_rs1", bus.out_rs1_data, 32'h0);

    // write-back then R-type r3 = r1 op r2
    bus.wb_en = 1; bus.wb_addr = 5'd1; bus.wb_data = 32'h11; step();
    bus.wb_addr = 5'd2; bus.wb_data = 32'h22; step();
    bus.wb_en = 0;
    bus.in_valid = 1; bus.in_instr = 32'h00221800; bus.in_pc = 32'h104;
    step(); bus.in_valid = 0;
    check("r_rs1", bus.out_rs1_data, 32'h11);
    check("r_rs2", bus.out_rs2_data, 32'h22);
    check("r_rd", 32'(bus.out_rd), 32'd3);
    check("r_alu", 32'(bus.out_alu_ctrl), 32'h1);
    check("r_imm", bus.out_imm, 32'h0);

    // load r4, then R-type using r4 -> one bubble
    bus.in_valid = 1; bus.in_instr = 32'h0C240010; bus.in_pc = 32'h108;
    step();
    check("ld_mr", 32'(bus.out_mem_read), 32'h1);
    bus.in_instr = 32'h00823000; bus.in_pc = 32'h10C;
    #1;
    check("lu_in_ready", 32'(bus.in_ready), 32'h0);
    step();
    check("lu_bubble", 32'(bus.out_valid), 32'h0);
    check("lu_ready_after", 32'(bus.in_ready), 32'h1);
    step(); bus.in_valid = 0;
    check("lu_issue_valid", 32'(bus.out_valid), 32'h1);
    check("lu_issue_rd", 32'(bus.out_rd), 32'd6);

    // stall for 3 cycles
    bus.in_valid = 1; bus.in_instr = 32'h04220005; bus.in_pc = 32'h200;
    step();
    bus.out_ready = 0; bus.in_instr = 32'h04430007; bus.in_pc = 32'h204;
    s_pc = bus.out_pc; s_imm = bus.out_imm; s_rd = bus.out_rd;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_in_ready", 32'(bus.in_ready), 32'h0);
      check("stall_valid", 32'(bus.out_valid), 32'h1);
      check("stall_pc", bus.out_pc, s_pc);
      check("stall_imm", bus.out_imm, s_imm);
      check("stall_rd", 32'(bus.out_rd), 32'(s_rd));
    end
    check("stall_pc_lit", s_pc, 32'h200);
    bus.out_ready = 1; #1;
    check("release_in_ready", 32'(bus.in_ready), 32'h1);
    step(); bus.in_valid = 0;
    check("release_pc", bus.out_pc, 32'h204);

    // flush, then an illegal opcode
    bus.in_valid = 1; bus.flush = 1; bus.in_instr = 32'h04220001; #1;
    check("flush_in_ready", 32'(bus.in_ready), 32'h0);
    step();
    check("flush_valid", 32'(bus.out_valid), 32'h0);
    bus.flush = 0; bus.in_instr = 32'hFC000000; bus.in_pc = 32'h300;
    step(); bus.in_valid = 0;
    check("ill_flag", 32'(bus.out_illegal), 32'h1);
    check("ill_rw", 32'(bus.out_reg_write), 32'h0);
    check("ill_valid", 32'(bus.out_valid), 32'h1);

    // write-back to rs in the accept cycle
    bus.wb_en = 1; bus.wb_addr = 5'd1; bus.wb_data = 32'h99;
    bus.in_valid = 1; bus.in_instr = 32'h04220000; bus.in_pc = 32'h400;
    step(); bus.wb_en = 0;
`ifdef ID_BYPASS_EN
    b_exp = 32'h99;
`else
    b_exp = 32'h11;
`endif
    check("wb_same_cycle_rs1", bus.out_rs1_data, b_exp);
    step(); bus.in_valid = 0;
    check("wb_next_cycle_rs1", bus.out_rs1_data, 32'h99);

    // async reset in the middle of a stall
    bus.out_ready = 0; bus.in_valid = 1; bus.in_pc = 32'h500;
    step(); step();
    #2; rst_n = 0; #1;
    check("rst_valid", 32'(bus.out_valid), 32'h0);
    check("rst_pc", bus.out_pc, 32'h0);
    check("rst_rs1", bus.out_rs1_data, 32'h0);
    check("rst_rs2", bus.out_rs2_data, 32'h0);
    check("rst_imm", bus.out_imm, 32'h0);
    check("rst_rd", 32'(bus.out_rd), 32'h0);
    check("rst_alu", 32'(bus.out_alu_ctrl), 32'h0);
    check("rst_flags", {29'h0, bus.out_reg_write, bus.out_mem_read, bus.out_illegal}, 32'h0);
    idle_inputs();
    @(negedge clk); rst_n = 1'b1;
    bus.in_valid = 1; bus.in_instr = 32'h04220000;
    step(); bus.in_valid = 0;
    check("rf_cleared_rs1", bus.out_rs1_data, 32'h0);

    // randomized traffic
    repeat (3000) begin
      case ($urandom_range(0, 5))
        0: op = 6'd0;
        1: op = 6'd1;
        2: op = 6'd2;
        3: op = 6'd3;
        4: op = 6'h3F;
        default: op = 6'($urandom_range(4, 62));
      endcase
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.in_instr  = {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                       5'($urandom_range(0, 7)), 11'($urandom)};
      bus.in_pc     = $urandom;
      bus.wb_en     = 1'($urandom_range(0, 1));
      bus.wb_addr   = 5'($urandom_range(0, 7));
      bus.wb_data   = $urandom;
      bus.flush     = ($urandom_range(0, 15) == 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    idle_inputs();
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/id_stage_pipe.md
Name: id_stage_pipe

Overview:
Parametrised instruction-decode pipeline stage with an integrated register file, registered ID/EX outputs and valid/ready handshakes on both sides. It sits between the fetch stage and the execute stage, and takes the write-back port from the end of the pipe. It decodes R, I (addi), J and load formats, sign-extends immediates and reads source operands. It detects load-use hazards and inserts one bubble, flushes on request, and flags unknown opcodes.

Parameters:
DATA_W, 32, register, PC and immediate width (min 16)
NUM_REGS, 32, register count (power of 2, 2..32); register 0 hardwired to zero
ADDR_W, 5, register address width, $clog2(NUM_REGS) fixed at 5 in encoding; upper address bits ignored when NUM_REGS<32

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  fetch presents instruction
in_ready  out  1  stage accepts instruction this cycle
in_instr  in  32  instruction word
in_pc  in  DATA_W  instruction address
wb_en  in  1  register-file write enable
wb_addr  in  5  write address
wb_data  in  DATA_W  write data
flush  in  1  synchronous kill of ID/EX contents and input
out_valid  out  1  ID/EX register holds a valid op
out_ready  in  1  execute accepts op
out_pc  out  DATA_W  pc of op
out_rs1_data  out  DATA_W  value of rs
out_rs2_data  out  DATA_W  value of rt
out_imm  out  DATA_W  sign-extended instr[15:0]
out_rd  out  5  destination register
out_alu_ctrl  out  4  ALU operation
out_reg_write  out  1  op writes register file
out_mem_read  out  1  op is a load
out_illegal  out  1  opcode not recognised

Behaviour:
- Field slicing: opcode = [31:26], rs = [25:21], rt = [20:16], rd = [15:11], imm = [15:0].
- Decode table:
  - 000000 R-type: alu 0001, dest rd, reg_write 1, imm 0.
  - 000001 addi: alu 0010, dest rt, reg_write 1.
  - 000010 J: alu 0000, dest 0, reg_write 0.
  - 000011 load: alu 0011, dest rt, reg_write 1, mem_read 1.
  - Any other opcode: alu 0000, reg_write 0, mem_read 0, illegal 1. The op still travels with out_valid=1.
- Writes to destination 0 force reg_write=0.
- Register file: one write per cycle on the rising edge when wb_en=1 and wb_addr!=0. Reads of register 0 return 0.
- out_imm is imm sign-extended to DATA_W.
- Handshake:
  - A transfer occurs on a cycle where valid and ready are both high.
  - in_ready = !flush && !hazard && (!out_valid || out_ready).
  - ID/EX contents hold stable while out_valid && !out_ready.
- Load-use hazard:
  - Condition: in_valid && out_valid && out_mem_read && out_rd!=0 && (out_rd==rs || (opcode==000000 && out_rd==rt)).
  - On hazard: in_ready=0. If out_ready=1, the next cycle has out_valid=0 (one bubble), and the instruction is accepted the cycle after.
- Flush: highest priority. On the next edge out_valid=0. Input is not accepted during the flush cycle. Register-file writes still occur.
- Latency: accepted instruction appears on the outputs on the next rising edge (1 cycle).
- Reset (async assert, sync-safe release):
  - out_valid=0, all out_* data fields=0, out_alu_ctrl=0, flags=0.
  - All registers=0.
  - in_ready=1 after release.

Optional Feature:
ID_BYPASS_EN:
- Defined: if wb_en=1, wb_addr!=0 and wb_addr equals rs/rt in the accept cycle, wb_data is forwarded into out_rs1_data/out_rs2_data.
- Undefined: the pre-write register value is captured, and the write becomes visible from the next cycle.

Test Plan:
- Reset, then addi 0x0405FFFF accepted -> next cycle out_valid=1, out_rd=5, out_alu_ctrl=0010, out_imm=0xFFFFFFFF, out_reg_write=1, out_rs1_data=0.
- Write-back r1=0x11, r2=0x22, then R-type 0x00221800 -> out_rs1_data=0x11, out_rs2_data=0x22, out_rd=3, out_alu_ctrl=0001.
- Load 0x0C240010, then R-type 0x00823000 with out_ready=1 -> one cycle in_ready=0 and out_valid=0 bubble, then the R-type issues with out_rd=6.
- out_ready=0 for 3 cycles with out_valid=1 -> all out_* stable, in_ready=0; release -> next op advances.
- flush=1 with in_valid=1 -> in_ready=0, next cycle out_valid=0; opcode 0x3F instruction -> out_illegal=1, out_reg_write=0.
- wb_en with wb_addr=rs in the same cycle as accept -> with ID_BYPASS_EN out_rs1_data=wb_data; without it, the old value; rst_n low mid-stall -> all outputs 0 asynchronously.
